cpu_controller: RTL and testbench

Multi-cycle control unit that issues the control signals the RISC datapath consumes. Holds a 16-bit instruction register, decodes the instruction fields and sequences a Moore state machine through register reads, ALU operation and register write-back. Presents a start/wait handshake to the surrounding CPU or test harness. The datapath's `mdata` and `PC` inputs are tied off outside this block.

---
 rtl/cpu_pkg.sv | 74 +++++++
 rtl/cpu_controller_decoder.sv | 32 +++
 rtl/cpu_controller.sv | 165 ++++++++++++++++
 tb/tb_cpu_controller.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle RISC control unit: FSM states,
// instruction field encodings, datapath select codes and a decode helper.
package cpu_pkg;

  // Controller states
  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_OPERATE,
    S_WRITE_REG,
    S_WRITE_IMM
  } state_t;

  // Instruction classes recognised by the controller
  typedef enum logic [2:0] {
    INS_MOV_IMM,
    INS_MOV_REG,
    INS_ADD,
    INS_CMP,
    INS_AND,
    INS_MVN,
    INS_UNDEF
  } instr_t;

  // Opcode field values (IR[15:13])
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // Op field values (IR[12:11]) under each opcode
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // Register-file write-back source select
  localparam logic [1:0] VSEL_MDATA = 2'b00;
  localparam logic [1:0] VSEL_IMM8  = 2'b01;
  localparam logic [1:0] VSEL_PC    = 2'b10;
  localparam logic [1:0] VSEL_C     = 2'b11;

  // ALU operation codes (the op field drives ALUop directly)
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  // Register-number field select for the decoder
  localparam logic [1:0] NSEL_RN = 2'd0;
  localparam logic [1:0] NSEL_RM = 2'd1;
  localparam logic [1:0] NSEL_RD = 2'd2;

  // Map opcode/op onto an instruction class; anything unknown is INS_UNDEF
  function automatic instr_t decodeInstr(input logic [2:0] opcode, input logic [1:0] op);
    instr_t result;
    result = INS_UNDEF;
    if (opcode == OPC_MOV) begin
      if (op == OP_MOV_IMM)      result = INS_MOV_IMM;
      else if (op == OP_MOV_REG) result = INS_MOV_REG;
    end else if (opcode == OPC_ALU) begin
      case (op)
        OP_ADD:  result = INS_ADD;
        OP_CMP:  result = INS_CMP;
        OP_AND:  result = INS_AND;
        default: result = INS_MVN;
      endcase
    end
    return result;
  endfunction

endpackage

// File: rtl/cpu_controller_decoder.sv
// Combinational instruction field extractor: splits the IR into its fields,
// sign-extends the immediates and muxes out the requested register number.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] i_ir,
  input  logic [1:0]  i_nsel,
  output logic [2:0]  o_regNum,
  output logic [2:0]  o_opcode,
  output logic [1:0]  o_op,
  output logic [1:0]  o_shift,
  output logic [15:0] o_sximm8,
  output logic [15:0] o_sximm5
);

  assign o_opcode = i_ir[15:13];
  assign o_op     = i_ir[12:11];
  assign o_shift  = i_ir[4:3];
  assign o_sximm8 = {{8{i_ir[7]}}, i_ir[7:0]};
  assign o_sximm5 = {{11{i_ir[4]}}, i_ir[4:0]};

  // Pick Rn, Rm or Rd according to which operand the controller needs next
  always_comb begin
    o_regNum = i_ir[10:8];
    case (i_nsel)
      NSEL_RM: o_regNum = i_ir[2:0];
      NSEL_RD: o_regNum = i_ir[7:5];
      default: o_regNum = i_ir[10:8];
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle control unit: instruction register plus a Moore FSM whose
// outputs are registered, computed alongside each state transition so they
// always reflect the state being entered.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  input  logic        Z,
  input  logic        N,
  input  logic        V,
  output logic        w,
  output logic [2:0]  writenum,
  output logic [2:0]  readnum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  state_t      r_state;
  logic [15:0] r_ir;
  logic [1:0]  w_nsel;
  logic [2:0]  w_regNum;
  logic [2:0]  w_opcode;
  logic [1:0]  w_op;
  logic [1:0]  w_shift;
  instr_t      w_instr;
  logic        w_unusedFlags;

  // Status flags are reserved for future branch support
  assign w_unusedFlags = ^{Z, N, V};

  assign w_instr = decodeInstr(w_opcode, w_op);
  assign ALUop   = w_op;

  instr_decoder u_decoder (
    .i_ir     (r_ir),
    .i_nsel   (w_nsel),
    .o_regNum (w_regNum),
    .o_opcode (w_opcode),
    .o_op     (w_op),
    .o_shift  (w_shift),
    .o_sximm8 (sximm8),
    .o_sximm5 (sximm5)
  );

  // Select the register field that the state being entered next will present
  always_comb begin
    w_nsel = NSEL_RN;
    case (r_state)
      S_DECODE:  if (w_instr == INS_MOV_REG || w_instr == INS_MVN) w_nsel = NSEL_RM;
      S_GET_A:   w_nsel = NSEL_RM;
      S_OPERATE: w_nsel = NSEL_RD;
      default:   w_nsel = NSEL_RN;
    endcase
  end

  // Instruction register only accepts a new word while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          r_ir <= 16'h0000;
    else if (r_state == S_WAIT && load) r_ir <= in;
  end

  // State sequencing with registered Moore outputs for the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_WAIT;
      w        <= 1'b1;
      write    <= 1'b0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      asel     <= 1'b0;
      bsel     <= 1'b0;
      readnum  <= 3'b000;
      writenum <= 3'b000;
      vsel     <= VSEL_MDATA;
      shift    <= 2'b00;
    end else begin
      w        <= 1'b0;
      write    <= 1'b0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      asel     <= 1'b0;
      bsel     <= 1'b0;
      readnum  <= 3'b000;
      writenum <= 3'b000;
      vsel     <= VSEL_MDATA;
      shift    <= 2'b00;
      case (r_state)
        S_WAIT: begin
          if (s) r_state <= S_DECODE;
          else   w       <= 1'b1;
        end
        S_DECODE: begin
          case (w_instr)
            INS_MOV_IMM: begin
              r_state  <= S_WRITE_IMM;
              writenum <= w_regNum;
              vsel     <= VSEL_IMM8;
              write    <= 1'b1;
            end
            INS_MOV_REG, INS_MVN: begin
              r_state <= S_GET_B;
              readnum <= w_regNum;
              loadb   <= 1'b1;
            end
            INS_ADD, INS_CMP, INS_AND: begin
              r_state <= S_GET_A;
              readnum <= w_regNum;
              loada   <= 1'b1;
            end
            default: begin
              r_state <= S_WAIT;
              w       <= 1'b1;
            end
          endcase
        end
        S_GET_A: begin
          r_state <= S_GET_B;
          readnum <= w_regNum;
          loadb   <= 1'b1;
        end
        S_GET_B: begin
          r_state <= S_OPERATE;
          shift   <= w_shift;
          asel    <= (w_instr == INS_MOV_REG) || (w_instr == INS_MVN);
          loads   <= (w_instr == INS_CMP);
          loadc   <= (w_instr != INS_CMP);
        end
        S_OPERATE: begin
          if (w_instr == INS_CMP) begin
            r_state <= S_WAIT;
            w       <= 1'b1;
          end else begin
            r_state  <= S_WRITE_REG;
            writenum <= w_regNum;
            vsel     <= VSEL_C;
            write    <= 1'b1;
          end
        end
        default: begin
          r_state <= S_WAIT;
          w       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed self-checking bench for cpu_controller. Each task walks one
// instruction or scenario edge by edge and compares a packed snapshot of the
// control outputs against hand-derived values.
module tb_cpu_controller;

  logic        clk;
  logic        reset;
  logic        s;
  logic        load;
  logic [15:0] in;
  logic        Z, N, V;
  logic        w;
  logic [2:0]  writenum, readnum;
  logic        write, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8, sximm5;

  int vectors;
  int miscompares;

  logic [17:0] obs;
  logic [17:0] exp;

  cpu_controller dut (
    .clk      (clk),
    .reset    (reset),
    .s        (s),
    .load     (load),
    .in       (in),
    .Z        (Z),
    .N        (N),
    .V        (V),
    .w        (w),
    .writenum (writenum),
    .readnum  (readnum),
    .write    (write),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .vsel     (vsel),
    .shift    (shift),
    .ALUop    (ALUop),
    .sximm8   (sximm8),
    .sximm5   (sximm5)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {w, write, loada, loadb, loadc, loads, asel, bsel,
                readnum, writenum, vsel, shift};

  // Pack expected control values in the same order as obs
  function automatic logic [17:0] mk(input logic ew, input logic ewr, input logic ela,
                                     input logic elb, input logic elc, input logic els,
                                     input logic eas, input logic ebs, input logic [2:0] ern,
                                     input logic [2:0] ewn, input logic [1:0] evs,
                                     input logic [1:0] esh);
    return {ew, ewr, ela, elb, elc, els, eas, ebs, ern, ewn, evs, esh};
  endfunction

  // Advance one clock edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load an instruction word while idle, without starting it
  task automatic loadInstr(input logic [15:0] word);
    in   = word;
    load = 1'b1;
    s    = 1'b0;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    exp = mk(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 2'b00, 2'b00);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %h want %h", obs, exp);
    end
    vectors++;
    if ({sximm8, sximm5} !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_imm: got %h/%h want 0000/0000", sximm8, sximm5);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_mov_imm();
    loadInstr(16'hD3FB);
    vectors++;
    if ({sximm8, sximm5} !== {16'hFFFB, 16'hFFFB}) begin
      miscompares++;
      $display("[TB] FAIL mov_imm_sx: got %h/%h want FFFB/FFFB", sximm8, sximm5);
    end
    s = 1'b1;
    step();
    s = 1'b0;
    exp = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 2'b00, 2'b00);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL mov_imm_decode: got %h want %h", obs, exp);
    end
    step();
    exp = mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 3'd3, 2'b01, 2'b00);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL mov_imm_write: got %h want %h", obs, exp);
    end
    step();
    exp = mk(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 2'b00, 2'b00);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL mov_imm_done: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_add();
    loadInstr(16'hA148);
    s = 1'b1;
    step();
    s = 1'b0;
    step();
    exp = mk(0, 0, 1, 0, 0, 0, 0, 0, 3'd1, 3'd0, 2'b00, 2'b00);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL add_get_a: got %h want %h", obs, exp);
    end
    step();
    exp = mk(0, 0, 0, 1, 0, 0, 0, 0, 3'd0, 3'd0, 2'b00, 2'b00);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL add_get_b: got %h want %h", obs, exp);
    end
    step();
    exp = mk(0, 0, 0, 0, 1, 0, 0, 0, 3'd0, 3'd0, 2'b00, 2'b01);
    vectors++;
    if (obs !== exp || ALUop !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL add_operate: got %h alu %b want %h alu 00", obs, ALUop, exp);
    end
    step();
    exp = mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 3'd2, 2'b11, 2'b00);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL add_write_reg: got %h want %h", obs, exp);
    end
    step();
    exp = mk(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 2'b00, 2'b00);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL add_done: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_cmp();
    loadInstr(16'hA902);
    s = 1'b1;
    step();
    s = 1'b0;
    step();
    exp = mk(0, 0, 1, 0, 0, 0, 0, 0, 3'd1, 3'd0, 2'b00, 2'b00);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL cmp_get_a: got %h want %h", obs, exp);
    end
    step();
    exp = mk(0, 0, 0, 1, 0, 0, 0, 0, 3'd2, 3'd0, 2'b00, 2'b00);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL cmp_get_b: got %h want %h", obs, exp);
    end
    step();
    exp = mk(0, 0, 0, 0, 0, 1, 0, 0, 3'd0, 3'd0, 2'b00, 2'b00);
    vectors++;
    if (obs !== exp || ALUop !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL cmp_operate: got %h alu %b want %h alu 01", obs, ALUop, exp);
    end
    step();
    exp = mk(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 2'b00, 2'b00);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL cmp_done: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_mvn();
    loadInstr(16'hB887);
    s = 1'b1;
    step();
    s = 1'b0;
    step();
    exp = mk(0, 0, 0, 1, 0, 0, 0, 0, 3'd7, 3'd0, 2'b00, 2'b00);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL mvn_get_b: got %h want %h", obs, exp);
    end
    step();
    exp = mk(0, 0, 0, 0, 1, 0, 1, 0, 3'd0, 3'd0, 2'b00, 2'b00);
    vectors++;
    if (obs !== exp || ALUop !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL mvn_operate: got %h alu %b want %h alu 11", obs, ALUop, exp);
    end
    step();
    exp = mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 3'd4, 2'b11, 2'b00);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL mvn_write_reg: got %h want %h", obs, exp);
    end
    step();
    exp = mk(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 2'b00, 2'b00);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL mvn_done: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_undefined();
    loadInstr(16'h0000);
    s = 1'b1;
    step();
    s = 1'b0;
    exp = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 2'b00, 2'b00);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL undef_decode: got %h want %h", obs, exp);
    end
    step();
    exp = mk(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 2'b00, 2'b00);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL undef_return: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_load_during_exec();
    loadInstr(16'hA148);
    s = 1'b1;
    step();
    s    = 1'b0;
    load = 1'b1;
    in   = 16'hD3FB;
    step();
    step();
    step();
    exp = mk(0, 0, 0, 0, 1, 0, 0, 0, 3'd0, 3'd0, 2'b00, 2'b01);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL busy_load_operate: got %h want %h", obs, exp);
    end
    load = 1'b0;
    step();
    exp = mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 3'd2, 2'b11, 2'b00);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL busy_load_write: got %h want %h", obs, exp);
    end
    step();
    vectors++;
    if (sximm8 !== 16'h0048 || sximm5 !== 16'h0008) begin
      miscompares++;
      $display("[TB] FAIL busy_load_ir: got %h/%h want 0048/0008", sximm8, sximm5);
    end
  endtask

  task automatic test_load_and_start();
    in   = 16'hD3FB;
    load = 1'b1;
    s    = 1'b1;
    step();
    load = 1'b0;
    s    = 1'b0;
    step();
    exp = mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 3'd3, 2'b01, 2'b00);
    vectors++;
    if (obs !== exp || sximm8 !== 16'hFFFB) begin
      miscompares++;
      $display("[TB] FAIL load_start_write: got %h imm %h want %h imm FFFB", obs, sximm8, exp);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [4:0] wSeq;
    logic [4:0] wrSeq;
    loadInstr(16'hD3FB);
    s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      wSeq[i]  = w;
      wrSeq[i] = write;
    end
    s = 1'b0;
    vectors++;
    if (wSeq !== 5'b00100 || wrSeq !== 5'b10010) begin
      miscompares++;
      $display("[TB] FAIL b2b_seq: got w %b wr %b want w 00100 wr 10010", wSeq, wrSeq);
    end
    step();
    step();
  endtask

  task automatic test_reset_mid();
    logic sawWrite;
    sawWrite = 1'b0;
    loadInstr(16'hA148);
    s = 1'b1;
    step();
    s = 1'b0;
    step();
    step();
    exp = mk(0, 0, 0, 1, 0, 0, 0, 0, 3'd0, 3'd0, 2'b00, 2'b00);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_get_b: got %h want %h", obs, exp);
    end
    #2;
    reset = 1'b1;
    #1;
    exp = mk(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 2'b00, 2'b00);
    vectors++;
    if (obs !== exp || sximm8 !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_immediate: got %h imm %h want %h imm 0000", obs, sximm8, exp);
    end
    if (write) sawWrite = 1'b1;
    step();
    if (write) sawWrite = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (write) sawWrite = 1'b1;
    end
    vectors++;
    if (sawWrite !== 1'b0 || w !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_no_write: got write-seen %b w %b want 0 1", sawWrite, w);
    end
  endtask

  // Run every scenario in order and print the summary
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    s           = 1'b0;
    load        = 1'b0;
    in          = 16'h0000;
    Z           = 1'b0;
    N           = 1'b0;
    V           = 1'b0;
    test_reset();
    test_mov_imm();
    test_add();
    test_cmp();
    test_mvn();
    test_undefined();
    test_load_during_exec();
    test_load_and_start();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
